// File: rtl/wishbone_arb_interconn.sv
// Round-robin Wishbone arbiter and address-decoding interconnect, N masters to M slaves.
// Optional slave-response timeout is enabled by defining WB_TIMEOUT_EN.
module wishbone_arb_interconn #(
  parameter int unsigned                NUM_MASTERS    = 2,
  parameter int unsigned                NUM_SLAVES     = 4,
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_ADDRESS  = {32'h00040000, 32'h00030000,
                                                          32'h00020000, 32'h00010000},
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_SIZE     = {4{32'h00000100}},
  parameter int unsigned                TIMEOUT_CYCLES = 16,
  localparam int unsigned               GrantW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  localparam int unsigned               SlvW   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_cyc,
  input  logic [NUM_MASTERS-1:0]    m_stb,
  input  logic [NUM_MASTERS-1:0]    m_we,
  input  logic [32*NUM_MASTERS-1:0] m_adr,
  input  logic [32*NUM_MASTERS-1:0] m_dat_w,
  input  logic [4*NUM_MASTERS-1:0]  m_sel,
  output logic [32*NUM_MASTERS-1:0] m_dat_r,
  output logic [NUM_MASTERS-1:0]    m_ack,
  output logic [NUM_MASTERS-1:0]    m_err,
  output logic [NUM_SLAVES-1:0]     s_cyc,
  output logic [NUM_SLAVES-1:0]     s_stb,
  output logic                      s_we,
  output logic [31:0]               s_adr,
  output logic [31:0]               s_dat_w,
  output logic [3:0]                s_sel,
  input  logic [32*NUM_SLAVES-1:0]  s_dat_r,
  input  logic [NUM_SLAVES-1:0]     s_ack,
  input  logic [NUM_SLAVES-1:0]     s_err,
  input  logic [6:0]                switches,
  output logic [1:0]                mode_out,
  output logic [GrantW-1:0]         grant_id,
  output logic                      bus_busy
);

  typedef enum logic [1:0] {StIdle, StGrant, StErrResp} state_e;

  state_e            state_q, state_d;
  logic [GrantW-1:0] grant_q, grant_d, last_q, last_d, rr_sel;
  logic              rr_found;
  logic [1:0]        mode_q;

  logic              mst_cyc, mst_stb, mst_we;
  logic [31:0]       mst_adr, mst_dat_w;
  logic [3:0]        mst_sel;
  logic              hit;
  logic [SlvW-1:0]   hit_idx;
  logic              resp_ack, resp_err;
  logic [31:0]       resp_dat;
  logic              active;
  logic              tmo_fire;

  // Granted master's request bus.
  always_comb begin
    mst_cyc   = 1'b0;
    mst_stb   = 1'b0;
    mst_we    = 1'b0;
    mst_adr   = '0;
    mst_dat_w = '0;
    mst_sel   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == GrantW'(i)) begin
        mst_cyc   = m_cyc[i];
        mst_stb   = m_stb[i];
        mst_we    = m_we[i];
        mst_adr   = m_adr[i*32 +: 32];
        mst_dat_w = m_dat_w[i*32 +: 32];
        mst_sel   = m_sel[i*4 +: 4];
      end
    end
  end

  // Descending scan so the lowest matching slave index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if (({1'b0, mst_adr} >= {1'b0, SLAVE_ADDRESS[i*32 +: 32]}) &&
          ({1'b0, mst_adr} < ({1'b0, SLAVE_ADDRESS[i*32 +: 32]} +
                              {1'b0, SLAVE_SIZE[i*32 +: 32]}))) begin
        hit     = 1'b1;
        hit_idx = SlvW'(i);
      end
    end
  end

  always_comb begin
    resp_ack = 1'b0;
    resp_err = 1'b0;
    resp_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (hit_idx == SlvW'(i)) begin
        resp_ack = s_ack[i];
        resp_err = s_err[i];
        resp_dat = s_dat_r[i*32 +: 32];
      end
    end
  end

  // Gating on mst_cyc makes an abort drop s_cyc and discard late responses in the same cycle.
  assign active = (state_q == StGrant) && hit && mst_cyc;

  always_comb begin
    rr_sel   = last_q;
    rr_found = 1'b0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (!rr_found && m_cyc[i] && (i == (32'(last_q) + k) % NUM_MASTERS)) begin
          rr_sel   = GrantW'(i);
          rr_found = 1'b1;
        end
      end
    end
  end

`ifdef WB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q;
  logic            pending;

  assign pending  = active && mst_stb && !resp_ack && !resp_err;
  assign tmo_fire = pending && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
    end else if (pending && !tmo_fire) begin
      tmo_q <= tmo_q + TmoW'(1);
    end else begin
      tmo_q <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign tmo_fire       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (|m_cyc) begin
          state_d = StGrant;
          grant_d = rr_sel;
          last_d  = rr_sel;
        end
      end
      StGrant: begin
        if (!mst_cyc) begin
          state_d = StIdle;
        end else if ((mst_stb && !hit) || tmo_fire) begin
          state_d = StErrResp;
        end
      end
      StErrResp: state_d = StGrant;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    s_cyc   = '0;
    s_stb   = '0;
    m_ack   = '0;
    m_err   = '0;
    m_dat_r = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (active && (hit_idx == SlvW'(i))) begin
        s_cyc[i] = 1'b1;
        s_stb[i] = mst_stb;
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == GrantW'(i)) begin
        if (active) begin
          m_err[i]            = resp_err;
          m_ack[i]            = resp_ack && !resp_err;
          m_dat_r[i*32 +: 32] = resp_dat;
        end
        if (state_q == StErrResp) begin
          m_err[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= GrantW'(NUM_MASTERS - 1);
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      mode_q  <= switches[1:0];
    end
  end

  logic unused_switches;
  assign unused_switches = ^switches[6:2];

  assign s_we     = mst_we;
  assign s_adr    = mst_adr;
  assign s_dat_w  = mst_dat_w;
  assign s_sel    = mst_sel;
  assign mode_out = mode_q;
  assign grant_id = grant_q;
  assign bus_busy = (state_q != StIdle);

endmodule

// File: tb/tb_wishbone_arb_interconn.sv
// Directed bench for wishbone_arb_interconn with default parameters (2 masters, 4 slaves).
module tb_wishbone_arb_interconn;
  localparam int unsigned NM = 2;
  localparam int unsigned NS = 4;

  logic            clk, rst;
  logic [NM-1:0]   m_cyc, m_stb, m_we;
  logic [32*NM-1:0] m_adr, m_dat_w, m_dat_r;
  logic [4*NM-1:0] m_sel;
  logic [NM-1:0]   m_ack, m_err;
  logic [NS-1:0]   s_cyc, s_stb, s_ack, s_err;
  logic            s_we;
  logic [31:0]     s_adr, s_dat_w;
  logic [3:0]      s_sel;
  logic [32*NS-1:0] s_dat_r;
  logic [6:0]      switches;
  logic [1:0]      mode_out;
  logic [0:0]      grant_id;
  logic            bus_busy;

  int n_checks = 0;
  int n_errors = 0;

  wishbone_arb_interconn dut (
    .clk      (clk),
    .rst      (rst),
    .m_cyc    (m_cyc),
    .m_stb    (m_stb),
    .m_we     (m_we),
    .m_adr    (m_adr),
    .m_dat_w  (m_dat_w),
    .m_sel    (m_sel),
    .m_dat_r  (m_dat_r),
    .m_ack    (m_ack),
    .m_err    (m_err),
    .s_cyc    (s_cyc),
    .s_stb    (s_stb),
    .s_we     (s_we),
    .s_adr    (s_adr),
    .s_dat_w  (s_dat_w),
    .s_sel    (s_sel),
    .s_dat_r  (s_dat_r),
    .s_ack    (s_ack),
    .s_err    (s_err),
    .switches (switches),
    .mode_out (mode_out),
    .grant_id (grant_id),
    .bus_busy (bus_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mreq(input int m, input logic we, input logic [31:0] adr,
                      input logic [31:0] dat);
    m_cyc[m]            = 1'b1;
    m_stb[m]            = 1'b1;
    m_we[m]             = we;
    m_adr[m*32 +: 32]   = adr;
    m_dat_w[m*32 +: 32] = dat;
    m_sel[m*4 +: 4]     = 4'hF;
  endtask

  task automatic mdrop(input int m);
    m_cyc[m] = 1'b0;
    m_stb[m] = 1'b0;
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0; m_sel = '0;
    s_dat_r = '0; s_ack = '0; s_err = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int g;
    rst = 1'b0;
    switches = '0;
    clear_inputs();
    #2;
    chk("rst_busy", bus_busy, 1'b0);
    chk("rst_grant", grant_id, 1'b0);
    chk("rst_mode", mode_out, 2'b00);
    chk("rst_s_cyc", s_cyc, 4'b0000);
    chk("rst_s_stb", s_stb, 4'b0000);
    chk("rst_m_ack", m_ack, 2'b00);
    chk("rst_m_err", m_err, 2'b00);
    tick();
    tick();
    rst = 1'b1;

    // Single write to slave 1, ack two cycles after grant.
    mreq(0, 1'b1, 32'h00020004, 32'hDEADBEEF);
    #1;
    chk("t1_idle_busy", bus_busy, 1'b0);
    chk("t1_idle_s_cyc", s_cyc, 4'b0000);
    tick();
    chk("t1_busy", bus_busy, 1'b1);
    chk("t1_grant", grant_id, 1'b0);
    chk("t1_s_cyc", s_cyc, 4'b0010);
    chk("t1_s_stb", s_stb, 4'b0010);
    chk("t1_s_dat_w", s_dat_w, 32'hDEADBEEF);
    chk("t1_s_adr", s_adr, 32'h00020004);
    chk("t1_s_we", s_we, 1'b1);
    chk("t1_ack_c0", m_ack, 2'b00);
    tick();
    chk("t1_ack_c1", m_ack, 2'b00);
    tick();
    s_ack[1] = 1'b1;
    #1;
    chk("t1_ack_c2", m_ack, 2'b01);
    chk("t1_err_c2", m_err, 2'b00);
    tick();
    s_ack[1] = 1'b0;
    mdrop(0);
    #1;
    chk("t1_ack_after", m_ack, 2'b00);
    chk("t1_s_cyc_drop", s_cyc, 4'b0000);
    tick();
    chk("t1_release", bus_busy, 1'b0);
    chk("t1_grant_hold", grant_id, 1'b0);

    // Two masters contend, three single transfers each: grants alternate.
    do_reset();
    mreq(0, 1'b0, 32'h00010010, 32'h0);
    mreq(1, 1'b0, 32'h00030020, 32'h0);
    for (int k = 0; k < 6; k++) begin
      g = k % 2;
      tick();
      chk("rr_grant", grant_id, g[0]);
      chk("rr_s_cyc", s_cyc, (g == 0) ? 4'b0001 : 4'b0100);
      s_ack = (g == 0) ? 4'b0001 : 4'b0100;
      #1;
      chk("rr_ack", m_ack, (g == 0) ? 2'b01 : 2'b10);
      tick();
      s_ack = '0;
      mdrop(g);
      #1;
      chk("rr_abort_s_cyc", s_cyc, 4'b0000);
      tick();
      if (k < 4) begin
        mreq(g, 1'b0, (g == 0) ? 32'h00010010 : 32'h00030020, 32'h0);
      end
    end

    // Unmapped read by master 1.
    mreq(1, 1'b0, 32'h00050000, 32'h0);
    tick();
    chk("um_grant", grant_id, 1'b1);
    chk("um_s_cyc", s_cyc, 4'b0000);
    chk("um_err_c0", m_err, 2'b00);
    tick();
    chk("um_err", m_err, 2'b10);
    chk("um_ack", m_ack, 2'b00);
    chk("um_s_cyc_err", s_cyc, 4'b0000);
    chk("um_busy", bus_busy, 1'b1);
    tick();
    mdrop(1);
    #1;
    chk("um_err_once", m_err, 2'b00);
    tick();
    chk("um_release", bus_busy, 1'b0);

    // Simultaneous ack and err from slave 0; read data routing.
    mreq(0, 1'b0, 32'h00010000, 32'h0);
    tick();
    s_ack[0] = 1'b1;
    s_err[0] = 1'b1;
    s_dat_r[31:0] = 32'h12345678;
    #1;
    chk("pr_err", m_err, 2'b01);
    chk("pr_ack", m_ack, 2'b00);
    chk("pr_dat", m_dat_r, 64'h0000_0000_1234_5678);
    tick();
    s_ack = '0;
    s_err = '0;
    s_dat_r = '0;
    mdrop(0);
    tick();

    switches = 7'b0000010;
    #1;
    chk("mode_latency", mode_out, 2'b00);
    tick();
    chk("mode_10", mode_out, 2'b10);
    switches = 7'b1111101;
    tick();
    chk("mode_01", mode_out, 2'b01);

    // Silent slave 2.
    mreq(0, 1'b0, 32'h00030000, 32'h0);
    tick();
    chk("to_s_stb", s_stb, 4'b0100);
`ifdef WB_TIMEOUT_EN
    repeat (15) tick();
    chk("to_no_err_yet", m_err, 2'b00);
    tick();
    chk("to_err", m_err, 2'b01);
    chk("to_s_stb_drop", s_stb, 4'b0000);
    tick();
    mdrop(0);
    tick();
`else
    repeat (100) tick();
    chk("stall_busy", bus_busy, 1'b1);
    chk("stall_s_stb", s_stb, 4'b0100);
    chk("stall_no_err", m_err, 2'b00);
    mdrop(0);
    tick();
    tick();
`endif
    chk("to_release", bus_busy, 1'b0);

    // Reset during a pending access to slave 3.
    mreq(0, 1'b1, 32'h00040000, 32'hCAFE0000);
    tick();
    chk("ar_s_cyc", s_cyc, 4'b1000);
    #2;
    s_ack[3] = 1'b1;
    rst = 1'b0;
    #1;
    chk("ar_s_cyc_rst", s_cyc, 4'b0000);
    chk("ar_busy_rst", bus_busy, 1'b0);
    chk("ar_ack_rst", m_ack, 2'b00);
    chk("ar_err_rst", m_err, 2'b00);
    chk("ar_mode_rst", mode_out, 2'b00);
    clear_inputs();
    tick();
    rst = 1'b1;
    mreq(0, 1'b0, 32'h00010000, 32'h0);
    mreq(1, 1'b0, 32'h00030000, 32'h0);
    tick();
    chk("ar_first_grant", grant_id, 1'b0);
    chk("ar_first_s_cyc", s_cyc, 4'b0001);
    clear_inputs();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
